// File: rtl/z88_sram_bridge_pkg.sv
// Shared types and constants for the Z88 internal-RAM to 8-bit SRAM bridge.
// Holds the byte-cycle and sequencer state encodings, the byte-lane codes and
// the wait-count clamp used by the byte-cycle engine.
package z88_sram_bridge_pkg;

    typedef enum logic [2:0] {
        CYC_IDLE,
        CYC_RD_ACT,
        CYC_WR_SETUP,
        CYC_WR_PULSE,
        CYC_WR_HOLD
    } cyc_state_e;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_BYTE,
        SEQ_NEXT
    } seq_state_e;

    localparam logic [1:0] BE_LO   = 2'b10;
    localparam logic [1:0] BE_HI   = 2'b01;
    localparam logic [1:0] BE_WORD = 2'b00;
    localparam logic [1:0] BE_NONE = 2'b11;

    // Wait counts live in a 3-bit counter; out-of-range parameters are pinned
    // to the nearest legal value instead of silently wrapping.
    function automatic logic [2:0] clamp_wait(input int v, input int lo);
        logic [2:0] r;
        if (v < lo)
            r = 3'(lo);
        else if (v > 7)
            r = 3'd7;
        else
            r = 3'(v);
        return r;
    endfunction

endpackage

// File: rtl/z88_sram_bridge_byte_cycle.sv
// Runs one byte read or one byte write on the asynchronous SRAM strobes.
// Read : RD_ACT for 1+RD_WAIT cycles, done on the last one (data sampled there).
// Write: WR_SETUP (1) -> WR_PULSE (WR_PULSE cycles, we_n low unless
//        suppressed) -> WR_HOLD (1, data still driven), done on WR_HOLD.
module z88_sram_byte_cycle
    import z88_sram_bridge_pkg::*;
#(
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic write_i,
    input  logic wprot_i,
    output logic sram_ce_n_o,
    output logic sram_oe_n_o,
    output logic sram_we_n_o,
    output logic sram_dq_oe_o,
    output logic done_o
);

    localparam logic [2:0] RD_CNT = clamp_wait(RD_WAIT, 0);
    localparam logic [2:0] WR_CNT = clamp_wait(WR_PULSE, 1) - 3'd1;

    cyc_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CYC_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and strobe decode; strobes are pure functions of state so an
    // async reset releases the SRAM in the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sram_ce_n_o  = 1'b1;
        sram_oe_n_o  = 1'b1;
        sram_we_n_o  = 1'b1;
        sram_dq_oe_o = 1'b0;
        done_o       = 1'b0;
        unique case (state_q)
            CYC_IDLE: begin
                if (start_i) begin
                    if (write_i) begin
                        state_d = CYC_WR_SETUP;
                    end else begin
                        state_d = CYC_RD_ACT;
                        cnt_d   = RD_CNT;
                    end
                end
            end
            CYC_RD_ACT: begin
                sram_ce_n_o = 1'b0;
                sram_oe_n_o = 1'b0;
                if (cnt_q == 3'd0) begin
                    done_o  = 1'b1;
                    state_d = CYC_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            CYC_WR_SETUP: begin
                sram_ce_n_o  = 1'b0;
                sram_dq_oe_o = 1'b1;
                cnt_d        = WR_CNT;
                state_d      = CYC_WR_PULSE;
            end
            CYC_WR_PULSE: begin
                sram_ce_n_o  = 1'b0;
                sram_dq_oe_o = 1'b1;
                sram_we_n_o  = wprot_i;
                if (cnt_q == 3'd0) begin
                    state_d = CYC_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            CYC_WR_HOLD: begin
                sram_ce_n_o  = 1'b0;
                sram_dq_oe_o = 1'b1;
                done_o       = 1'b1;
                state_d      = CYC_IDLE;
            end
            default: begin
                state_d = CYC_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/z88_sram_bridge.sv
// Z88 internal-RAM bus responder driving a physical 8-bit asynchronous SRAM.
// Each 16-bit byte-enabled access becomes one byte cycle, or two (low lane,
// one idle NEXT cycle, high lane) for a full word.
// Optional feature macro: Z88_SRAM_WPROT_EN adds wprot/wprot_hit; when wprot
// is set a write runs its full timing but sram_we_n never goes low.
module z88_sram_bridge
    import z88_sram_bridge_pkg::*;
#(
    parameter int          RD_WAIT   = 1,
    parameter int          WR_PULSE  = 1,
    parameter logic [18:0] ADDR_MASK = 19'h3FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ram_ce_n,
    input  logic        ram_oe_n,
    input  logic        ram_we_n,
    input  logic [1:0]  ram_be_n,
    input  logic [18:0] ram_addr,
    input  logic [15:0] ram_wdata,
    output logic [15:0] ram_rdata,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [19:0] sram_addr,
    output logic [7:0]  sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [7:0]  sram_dq_i,
    output logic        busy,
    output logic        overrun
`ifdef Z88_SRAM_WPROT_EN
    ,
    input  logic        wprot,
    output logic        wprot_hit
`endif
);

    seq_state_e  seq_q, seq_d;
    logic        req, req_q, start, go;
    logic [18:0] addr_q, addr_d;
    logic        lane_q, lane_d;
    logic        word_q, word_d;
    logic        wr_q, wr_d;
    logic        wp_q, wp_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        overrun_q, overrun_d;
    logic        cyc_start, cyc_write, cyc_wprot, cyc_done;
    logic        wprot_in;

`ifdef Z88_SRAM_WPROT_EN
    logic hit_q;
    assign wprot_in  = wprot;
    assign wprot_hit = hit_q;

    // One-cycle flag in the cycle after a protected write is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hit_q <= 1'b0;
        else
            hit_q <= go & ~ram_we_n & wprot;
    end
`else
    assign wprot_in = 1'b0;
`endif

    assign req   = ~ram_ce_n & (~ram_oe_n | ~ram_we_n);
    assign start = req & ~req_q;
    assign go    = start & (seq_q == SEQ_IDLE) & (ram_be_n != BE_NONE);

    assign busy       = (seq_q != SEQ_IDLE);
    assign overrun    = overrun_q;
    assign ram_rdata  = rdata_q;
    assign sram_addr  = {addr_q, lane_q};
    assign sram_dq_o  = lane_q ? wdata_q[15:8] : wdata_q[7:0];

    // Request edge detector, latched access parameters, read data and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q     <= SEQ_IDLE;
            req_q     <= 1'b0;
            addr_q    <= 19'd0;
            lane_q    <= 1'b0;
            word_q    <= 1'b0;
            wr_q      <= 1'b0;
            wp_q      <= 1'b0;
            wdata_q   <= 16'd0;
            rdata_q   <= 16'd0;
            overrun_q <= 1'b0;
        end else begin
            seq_q     <= seq_d;
            req_q     <= req;
            addr_q    <= addr_d;
            lane_q    <= lane_d;
            word_q    <= word_d;
            wr_q      <= wr_d;
            wp_q      <= wp_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            overrun_q <= overrun_d;
        end
    end

    // Sequencer: accept a start in IDLE, run one or two byte cycles, merge read bytes.
    always_comb begin
        seq_d     = seq_q;
        addr_d    = addr_q;
        lane_d    = lane_q;
        word_d    = word_q;
        wr_d      = wr_q;
        wp_d      = wp_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        overrun_d = overrun_q;
        cyc_start = 1'b0;
        cyc_write = wr_q;
        cyc_wprot = wp_q;
        if (start && (seq_q != SEQ_IDLE))
            overrun_d = 1'b1;
        unique case (seq_q)
            SEQ_IDLE: begin
                // be_n=11 still consumes the edge (req_q tracks it) but issues nothing.
                if (go) begin
                    addr_d    = ram_addr & ADDR_MASK;
                    lane_d    = (ram_be_n == BE_HI);
                    word_d    = (ram_be_n == BE_WORD);
                    wr_d      = ~ram_we_n;
                    wp_d      = wprot_in & ~ram_we_n;
                    wdata_d   = ram_wdata;
                    cyc_start = 1'b1;
                    cyc_write = ~ram_we_n;
                    cyc_wprot = wprot_in & ~ram_we_n;
                    seq_d     = SEQ_BYTE;
                end
            end
            SEQ_BYTE: begin
                if (cyc_done) begin
                    if (!wr_q) begin
                        if (!word_q)
                            rdata_d = {sram_dq_i, sram_dq_i};
                        else if (lane_q)
                            rdata_d[15:8] = sram_dq_i;
                        else
                            rdata_d[7:0] = sram_dq_i;
                    end
                    if (word_q && !lane_q) begin
                        lane_d = 1'b1;
                        seq_d  = SEQ_NEXT;
                    end else begin
                        seq_d = SEQ_IDLE;
                    end
                end
            end
            SEQ_NEXT: begin
                cyc_start = 1'b1;
                seq_d     = SEQ_BYTE;
            end
            default: begin
                seq_d = SEQ_IDLE;
            end
        endcase
    end

    z88_sram_byte_cycle #(
        .RD_WAIT  (RD_WAIT),
        .WR_PULSE (WR_PULSE)
    ) u_cycle (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (cyc_start),
        .write_i      (cyc_write),
        .wprot_i      (cyc_wprot),
        .sram_ce_n_o  (sram_ce_n),
        .sram_oe_n_o  (sram_oe_n),
        .sram_we_n_o  (sram_we_n),
        .sram_dq_oe_o (sram_dq_oe),
        .done_o       (cyc_done)
    );

endmodule

// File: tb/tb_z88_sram_bridge.sv
// Scoreboard bench for z88_sram_bridge (RD_WAIT=1, WR_PULSE=2, default mask).
// A small SRAM model answers reads; each access pushes its expected response
// and a monitor checks it when busy drops.
module tb_z88_sram_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_ce_n, ram_oe_n, ram_we_n;
    logic [1:0]  ram_be_n;
    logic [18:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;
    logic [19:0] sram_addr;
    logic [7:0]  sram_dq_o, sram_dq_i;
    logic        busy, overrun;

    logic [7:0]  mem [0:1023];

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] rdata;
        int          busy_c;
        int          we_c;
        int          oe_c;
        int          next_c;
        int          drv_c;
        logic [19:0] addr0;
        logic        chk_dq;
        logic [7:0]  dq;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    z88_sram_bridge #(
        .RD_WAIT   (1),
        .WR_PULSE  (2),
        .ADDR_MASK (19'h3FFFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ram_ce_n   (ram_ce_n),
        .ram_oe_n   (ram_oe_n),
        .ram_we_n   (ram_we_n),
        .ram_be_n   (ram_be_n),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .busy       (busy),
        .overrun    (overrun)
    );

    // SRAM model: preloaded while reset is held, written on we_n low.
    assign sram_dq_i = mem[sram_addr[9:0]];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            mem[10'h246] <= 8'hA5;
            mem[10'h0A0] <= 8'h11;
            mem[10'h0A1] <= 8'h22;
            mem[10'h3FE] <= 8'h5A;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            mem[sram_addr[9:0]] <= sram_dq_o;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string nm, input logic [15:0] rd, input int bc,
                                input int wc, input int oc, input int nc, input int dc,
                                input logic [19:0] a0, input logic cd, input logic [7:0] dq);
        exp_t e;
        e.name = nm; e.rdata = rd; e.busy_c = bc; e.we_c = wc; e.oe_c = oc;
        e.next_c = nc; e.drv_c = dc; e.addr0 = a0; e.chk_dq = cd; e.dq = dq;
        return e;
    endfunction

    // Monitor: accumulate per-access observations while busy, compare on busy fall.
    initial begin
        int bc, wc, oc, nc, dc;
        logic [19:0] a0;
        logic [7:0]  dq0;
        logic got_a, got_dq, bprev;
        exp_t e;
        bc = 0; wc = 0; oc = 0; nc = 0; dc = 0; a0 = '0; dq0 = '0;
        got_a = 0; got_dq = 0; bprev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bc = 0; wc = 0; oc = 0; nc = 0; dc = 0; got_a = 0; got_dq = 0; bprev = 0;
            end else begin
                if (busy) begin
                    bc++;
                    if (!sram_oe_n) oc++;
                    if (!sram_we_n) wc++;
                    if (sram_dq_oe) dc++;
                    if (sram_ce_n && sram_oe_n && sram_we_n) nc++;
                    if (!sram_ce_n && !got_a) begin a0 = sram_addr; got_a = 1; end
                    if (!sram_we_n && !got_dq) begin dq0 = sram_dq_o; got_dq = 1; end
                end
                if (bprev && !busy) begin
                    if (sb.size() == 0) begin
                        check("unexpected_access_cycles", 32'(bc), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_rdata"}, 32'(ram_rdata), 32'(e.rdata));
                        check({e.name, "_busy_cycles"}, 32'(bc), 32'(e.busy_c));
                        check({e.name, "_we_low_cycles"}, 32'(wc), 32'(e.we_c));
                        check({e.name, "_oe_low_cycles"}, 32'(oc), 32'(e.oe_c));
                        check({e.name, "_next_cycles"}, 32'(nc), 32'(e.next_c));
                        check({e.name, "_dq_drive_cycles"}, 32'(dc), 32'(e.drv_c));
                        check({e.name, "_sram_addr"}, 32'(a0), 32'(e.addr0));
                        if (e.chk_dq) check({e.name, "_dq_o"}, 32'(dq0), 32'(e.dq));
                    end
                    bc = 0; wc = 0; oc = 0; nc = 0; dc = 0; got_a = 0; got_dq = 0;
                end
                bprev = busy;
            end
        end
    end

    task automatic bus_idle();
        ram_ce_n = 1'b1; ram_oe_n = 1'b1; ram_we_n = 1'b1;
        ram_be_n = 2'b11; ram_addr = '0; ram_wdata = '0;
    endtask

    task automatic wait_idle(input string nm);
        int  n;
        bit  done;
        n = 0; done = 0;
        @(posedge clk);
        while (!done) begin
            @(negedge clk);
            #1;
            if (!busy && sb.size() == 0) begin
                done = 1;
            end else begin
                n++;
                if (n > 50) begin
                    checks++; errors++;
                    $display("FAIL %s_timeout actual=busy expected=idle within 50 cycles", nm);
                    sb.delete();
                    done = 1;
                end
            end
        end
    endtask

    task automatic do_access(input string nm, input logic rd, input logic [1:0] be,
                             input logic [18:0] a, input logic [15:0] wd);
        @(negedge clk);
        ram_ce_n = 1'b0; ram_oe_n = ~rd; ram_we_n = rd;
        ram_be_n = be; ram_addr = a; ram_wdata = wd;
        wait_idle(nm);
        @(negedge clk);
        bus_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        bus_idle();
        repeat (3) @(negedge clk);
        check("rst_sram_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_sram_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_sram_we_n", 32'(sram_we_n), 32'd1);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_o", 32'(sram_dq_o), 32'd0);
        check("rst_rdata", 32'(ram_rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Byte read, low lane: 0x123 -> byte 0x246, data copied to both lanes.
        sb.push_back(mk("byte_rd", 16'hA5A5, 2, 0, 2, 0, 0, 20'h00246, 1'b0, 8'h00));
        do_access("byte_rd", 1'b1, 2'b10, 19'h00123, 16'h0000);

        // Byte write, high lane: 0x10 -> byte 0x21, data 0x3C, rdata untouched.
        sb.push_back(mk("byte_wr", 16'hA5A5, 4, 2, 0, 0, 4, 20'h00021, 1'b1, 8'h3C));
        do_access("byte_wr", 1'b0, 2'b01, 19'h00010, 16'h3C00);
        check("byte_wr_mem21", 32'(mem[10'h021]), 32'h3C);

        // Word read: low byte 0x11 then high byte 0x22 with one NEXT cycle.
        sb.push_back(mk("word_rd", 16'h2211, 5, 0, 4, 1, 0, 20'h000A0, 1'b0, 8'h00));
        do_access("word_rd", 1'b1, 2'b00, 19'h00050, 16'h0000);
        check("overrun_clear_before", 32'(overrun), 32'd0);

        // Overrun: a second ce_n falling edge during WR_PULSE is dropped.
        sb.push_back(mk("ovr_wr", 16'h2211, 4, 2, 0, 0, 4, 20'h00020, 1'b1, 8'h77));
        @(negedge clk);
        ram_ce_n = 1'b0; ram_oe_n = 1'b1; ram_we_n = 1'b0;
        ram_be_n = 2'b10; ram_addr = 19'h00010; ram_wdata = 16'h0077;
        @(negedge clk);
        ram_ce_n = 1'b1;
        @(negedge clk);
        check("ovr_in_pulse_we_n", 32'(sram_we_n), 32'd0);
        ram_ce_n = 1'b0;
        wait_idle("ovr_wr");
        repeat (4) @(negedge clk);
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_no_second_busy", 32'(busy), 32'd0);
        bus_idle();
        check("ovr_mem20", 32'(mem[10'h020]), 32'h77);
        check("ovr_mem21_kept", 32'(mem[10'h021]), 32'h3C);

        // be_n=11: start consumed, no SRAM cycle, busy stays low.
        @(negedge clk);
        ram_ce_n = 1'b0; ram_oe_n = 1'b0; ram_be_n = 2'b11; ram_addr = 19'h00005;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || !sram_ce_n) cnt++;
        end
        check("be11_no_cycle", 32'(cnt), 32'd0);
        bus_idle();

        // Address mask: 0x7FFFF masked to 0x3FFFF, lane appended -> 0x7FFFE.
        sb.push_back(mk("mask_rd", 16'h5A5A, 2, 0, 2, 0, 0, 20'h7FFFE, 1'b0, 8'h00));
        do_access("mask_rd", 1'b1, 2'b10, 19'h7FFFF, 16'h0000);

        // Async reset in the middle of WR_PULSE releases the SRAM at once.
        @(negedge clk);
        ram_ce_n = 1'b0; ram_oe_n = 1'b1; ram_we_n = 1'b0;
        ram_be_n = 2'b10; ram_addr = 19'h00030; ram_wdata = 16'h00EE;
        cnt = 0;
        while (sram_we_n && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("rstmid_reached_pulse", 32'(sram_we_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_we_n", 32'(sram_we_n), 32'd1);
        check("rstmid_ce_n", 32'(sram_ce_n), 32'd1);
        check("rstmid_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_overrun", 32'(overrun), 32'd0);
        check("rstmid_rdata", 32'(ram_rdata), 32'd0);
        bus_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
